// File: rtl/rl_md_pkg.sv
// Shared definitions for the range-limited MD pair generator: record layout,
// lane geometry and the generator state encoding.
package rl_md_pkg;

   localparam int DATA_WIDTH          = 32;
   localparam int PARTICLE_ID_WIDTH   = 20;
   localparam int NUM_FILTER          = 4;
   localparam int LOG2_NUM_FILTER     = 2;
   localparam int CELL_ADDR_WIDTH     = 8;
   localparam int NBR_WORD_ADDR_WIDTH = CELL_ADDR_WIDTH - LOG2_NUM_FILTER;
   // One extra bit so a full cell (64 words) can be counted.
   localparam int WORD_CNT_WIDTH      = NBR_WORD_ADDR_WIDTH + 1;

   // Position record {id, z, y, x}
   localparam int POS_REC_WIDTH = 3*DATA_WIDTH + PARTICLE_ID_WIDTH;
   localparam int POS_X_LSB     = 0;
   localparam int POS_Y_LSB     = DATA_WIDTH;
   localparam int POS_Z_LSB     = 2*DATA_WIDTH;
   localparam int POS_ID_LSB    = 3*DATA_WIDTH;

   typedef enum logic [2:0] {
      ST_IDLE     = 3'd0,
      ST_REF_RD   = 3'd1,
      ST_REF_WAIT = 3'd2,
      ST_STREAM   = 3'd3,
      ST_DRAIN    = 3'd4
   } gen_state_t;

   // Number of neighbor-cache words holding cnt particles: ceil(cnt / NUM_FILTER).
   function automatic logic [WORD_CNT_WIDTH-1:0] words_for_count(input logic [CELL_ADDR_WIDTH-1:0] cnt);
      logic [CELL_ADDR_WIDTH:0] sum;
      sum = {1'b0, cnt} + (CELL_ADDR_WIDTH+1)'(NUM_FILTER-1);
      return WORD_CNT_WIDTH'(sum >> LOG2_NUM_FILTER);
   endfunction

endpackage

// File: rtl/rl_pair_lane_mask.sv
// Per-lane pair-valid mask for one neighbor word: a lane is valid when its
// particle exists and, inside a single cell, lies strictly above the reference.
module rl_pair_lane_mask
   import rl_md_pkg::*;
(
   input  logic [NBR_WORD_ADDR_WIDTH-1:0] i_word,
   input  logic [CELL_ADDR_WIDTH-1:0]     i_ref_idx,
   input  logic [CELL_ADDR_WIDTH-1:0]     i_nbr_count,
   input  logic                           i_same_cell,
   output logic [NUM_FILTER-1:0]          o_mask
);

   logic [CELL_ADDR_WIDTH-1:0] w_idx;

   // Evaluate the particle index of each lane against count and half-shell rule.
   always_comb begin
      o_mask = '0;
      w_idx  = '0;
      for (int l = 0; l < NUM_FILTER; l++) begin
         w_idx     = {i_word, LOG2_NUM_FILTER'(l)};
         o_mask[l] = (w_idx < i_nbr_count) && (!i_same_cell || (w_idx > i_ref_idx));
      end
   end

endmodule

// File: rtl/rl_pair_generator.sv
// Pair source for the LJ force unit: walks every reference particle of the
// home cell and streams neighbor words, one particle per filter lane.
module rl_pair_generator
   import rl_md_pkg::*;
(
   input  logic                                    clk,
   input  logic                                    rst,
   input  logic                                    start,
   input  logic                                    same_cell,
   input  logic [CELL_ADDR_WIDTH-1:0]              ref_count,
   input  logic [CELL_ADDR_WIDTH-1:0]              nbr_count,
   output logic                                    busy,
   output logic                                    done,
   output logic                                    ref_rd_en,
   output logic [CELL_ADDR_WIDTH-1:0]              ref_rd_addr,
   input  logic [POS_REC_WIDTH-1:0]                ref_rd_data,
   output logic                                    nbr_rd_en,
   output logic [NBR_WORD_ADDR_WIDTH-1:0]          nbr_rd_addr,
   input  logic [NUM_FILTER*POS_REC_WIDTH-1:0]     nbr_rd_data,
   input  logic [NUM_FILTER-1:0]                   back_pressure_to_input,
   output logic [NUM_FILTER-1:0]                   input_valid,
   output logic [NUM_FILTER*PARTICLE_ID_WIDTH-1:0] ref_particle_id,
   output logic [NUM_FILTER*PARTICLE_ID_WIDTH-1:0] neighbor_particle_id,
   output logic [NUM_FILTER*DATA_WIDTH-1:0]        refx,
   output logic [NUM_FILTER*DATA_WIDTH-1:0]        refy,
   output logic [NUM_FILTER*DATA_WIDTH-1:0]        refz,
   output logic [NUM_FILTER*DATA_WIDTH-1:0]        neighborx,
   output logic [NUM_FILTER*DATA_WIDTH-1:0]        neighbory,
   output logic [NUM_FILTER*DATA_WIDTH-1:0]        neighborz,
   output gen_state_t                              dbg_state
);

   // Handshake: a lane pair is transferred in every cycle its input_valid bit
   // is high; the filter bank cannot refuse it, it can only raise its
   // back_pressure bit early enough that at most one more word lands.

   gen_state_t                     r_state, w_state_nxt;
   logic [CELL_ADDR_WIDTH-1:0]     r_ref_cnt, r_nbr_cnt, r_ref_idx, w_ref_idx_nxt;
   logic                           r_same;
   logic [WORD_CNT_WIDTH-1:0]      r_word, w_word_nxt, w_num_words, w_w0;
   logic [CELL_ADDR_WIDTH:0]       w_ref_inc;
   logic                           w_last_ref, w_done_nxt, r_done;
   logic [POS_REC_WIDTH-1:0]       r_ref_rec;
   logic                           r_rd_pend;
   logic [NUM_FILTER-1:0]          r_mask_pend, w_lane_mask;

   assign w_num_words = words_for_count(r_nbr_cnt);
   assign w_ref_inc   = {1'b0, r_ref_idx} + {{CELL_ADDR_WIDTH{1'b0}}, 1'b1};
   assign w_w0        = r_same ? WORD_CNT_WIDTH'(w_ref_inc >> LOG2_NUM_FILTER) : '0;
   assign w_last_ref  = (r_ref_idx == r_ref_cnt - CELL_ADDR_WIDTH'(1));

   assign busy      = (r_state != ST_IDLE);
   assign done      = r_done;
   assign dbg_state = r_state;

   rl_pair_lane_mask u_lane_mask (
      .i_word      (r_word[NBR_WORD_ADDR_WIDTH-1:0]),
      .i_ref_idx   (r_ref_idx),
      .i_nbr_count (r_nbr_cnt),
      .i_same_cell (r_same),
      .o_mask      (w_lane_mask)
   );

   // Next-state, index update and cache read strobes.
   always_comb begin
      w_state_nxt   = r_state;
      w_ref_idx_nxt = r_ref_idx;
      w_word_nxt    = r_word;
      w_done_nxt    = 1'b0;
      ref_rd_en     = 1'b0;
      ref_rd_addr   = '0;
      nbr_rd_en     = 1'b0;
      nbr_rd_addr   = '0;
      case (r_state)
         ST_IDLE: begin
            if (start) begin
               w_ref_idx_nxt = '0;
               if ((ref_count == '0) || (nbr_count == '0)) w_done_nxt  = 1'b1;
               else                                        w_state_nxt = ST_REF_RD;
            end
         end
         ST_REF_RD: begin
            ref_rd_en   = 1'b1;
            ref_rd_addr = r_ref_idx;
            w_state_nxt = ST_REF_WAIT;
         end
         ST_REF_WAIT: begin
            if (w_w0 >= w_num_words) begin
               // Nothing above this reference in the cell: skip it.
               if (w_last_ref) begin
                  w_state_nxt = ST_DRAIN;
               end else begin
                  w_ref_idx_nxt = r_ref_idx + CELL_ADDR_WIDTH'(1);
                  w_state_nxt   = ST_REF_RD;
               end
            end else begin
               w_word_nxt  = w_w0;
               w_state_nxt = ST_STREAM;
            end
         end
         ST_STREAM: begin
            if (!(|back_pressure_to_input)) begin
               nbr_rd_en   = 1'b1;
               nbr_rd_addr = r_word[NBR_WORD_ADDR_WIDTH-1:0];
               w_word_nxt  = r_word + WORD_CNT_WIDTH'(1);
               if (r_word == w_num_words - WORD_CNT_WIDTH'(1)) begin
                  if (w_last_ref) begin
                     w_state_nxt = ST_DRAIN;
                  end else begin
                     w_ref_idx_nxt = r_ref_idx + CELL_ADDR_WIDTH'(1);
                     w_state_nxt   = ST_REF_RD;
                  end
               end
            end
         end
         ST_DRAIN: begin
            // Once no read is in the RAM stage, the final word is in the
            // output register this cycle, so done follows it directly.
            if (!r_rd_pend) begin
               w_done_nxt  = 1'b1;
               w_state_nxt = ST_IDLE;
            end
         end
         default: w_state_nxt = ST_IDLE;
      endcase
   end

   // Control registers, latched job parameters, ref record and read pipeline.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_state     <= ST_IDLE;
         r_ref_idx   <= '0;
         r_word      <= '0;
         r_done      <= 1'b0;
         r_ref_cnt   <= '0;
         r_nbr_cnt   <= '0;
         r_same      <= 1'b0;
         r_ref_rec   <= '0;
         r_rd_pend   <= 1'b0;
         r_mask_pend <= '0;
      end else begin
         r_state   <= w_state_nxt;
         r_ref_idx <= w_ref_idx_nxt;
         r_word    <= w_word_nxt;
         r_done    <= w_done_nxt;
         if ((r_state == ST_IDLE) && start) begin
            r_ref_cnt <= ref_count;
            r_nbr_cnt <= nbr_count;
            r_same    <= same_cell;
         end
         if (r_state == ST_REF_WAIT) r_ref_rec <= ref_rd_data;
         r_rd_pend   <= nbr_rd_en;
         r_mask_pend <= nbr_rd_en ? w_lane_mask : '0;
      end
   end

   // Output register: loads a landed neighbor word with the broadcast ref.
   always_ff @(posedge clk) begin
      if (rst) begin
         input_valid          <= '0;
         ref_particle_id      <= '0;
         neighbor_particle_id <= '0;
         refx                 <= '0;
         refy                 <= '0;
         refz                 <= '0;
         neighborx            <= '0;
         neighbory            <= '0;
         neighborz            <= '0;
      end else begin
         input_valid <= r_rd_pend ? r_mask_pend : '0;
         if (r_rd_pend) begin
            for (int l = 0; l < NUM_FILTER; l++) begin
               ref_particle_id[l*PARTICLE_ID_WIDTH +: PARTICLE_ID_WIDTH] <= r_ref_rec[POS_ID_LSB +: PARTICLE_ID_WIDTH];
               refx[l*DATA_WIDTH +: DATA_WIDTH] <= r_ref_rec[POS_X_LSB +: DATA_WIDTH];
               refy[l*DATA_WIDTH +: DATA_WIDTH] <= r_ref_rec[POS_Y_LSB +: DATA_WIDTH];
               refz[l*DATA_WIDTH +: DATA_WIDTH] <= r_ref_rec[POS_Z_LSB +: DATA_WIDTH];
               neighbor_particle_id[l*PARTICLE_ID_WIDTH +: PARTICLE_ID_WIDTH] <=
                  nbr_rd_data[l*POS_REC_WIDTH + POS_ID_LSB +: PARTICLE_ID_WIDTH];
               neighborx[l*DATA_WIDTH +: DATA_WIDTH] <= nbr_rd_data[l*POS_REC_WIDTH + POS_X_LSB +: DATA_WIDTH];
               neighbory[l*DATA_WIDTH +: DATA_WIDTH] <= nbr_rd_data[l*POS_REC_WIDTH + POS_Y_LSB +: DATA_WIDTH];
               neighborz[l*DATA_WIDTH +: DATA_WIDTH] <= nbr_rd_data[l*POS_REC_WIDTH + POS_Z_LSB +: DATA_WIDTH];
            end
         end
      end
   end

endmodule

// File: tb/tb_rl_pair_generator.sv
// Bench for rl_pair_generator: random cell contents, a pair-list model built
// from the pairing rules, cache models and per-case timing expectations.
module tb_rl_pair_generator;
   import rl_md_pkg::*;

   localparam int REC_W = POS_REC_WIDTH;

   logic clk, rst, start, same_cell;
   logic [CELL_ADDR_WIDTH-1:0] ref_count, nbr_count;
   logic busy, done, ref_rd_en, nbr_rd_en;
   logic [CELL_ADDR_WIDTH-1:0] ref_rd_addr;
   logic [REC_W-1:0] ref_rd_data;
   logic [NBR_WORD_ADDR_WIDTH-1:0] nbr_rd_addr;
   logic [NUM_FILTER*REC_W-1:0] nbr_rd_data;
   logic [NUM_FILTER-1:0] back_pressure_to_input, input_valid;
   logic [NUM_FILTER*PARTICLE_ID_WIDTH-1:0] ref_particle_id, neighbor_particle_id;
   logic [NUM_FILTER*DATA_WIDTH-1:0] refx, refy, refz, neighborx, neighbory, neighborz;
   gen_state_t dbg_state;

   logic [REC_W-1:0] ref_rec [256];
   logic [REC_W-1:0] nbr_rec [256];
   logic [NUM_FILTER*REC_W-1:0] nbr_mem [64];
   logic [2*REC_W-1:0] exp_q[$];
   int n_checks, n_fail;

   rl_pair_generator dut (
      .clk(clk), .rst(rst), .start(start), .same_cell(same_cell),
      .ref_count(ref_count), .nbr_count(nbr_count), .busy(busy), .done(done),
      .ref_rd_en(ref_rd_en), .ref_rd_addr(ref_rd_addr), .ref_rd_data(ref_rd_data),
      .nbr_rd_en(nbr_rd_en), .nbr_rd_addr(nbr_rd_addr), .nbr_rd_data(nbr_rd_data),
      .back_pressure_to_input(back_pressure_to_input), .input_valid(input_valid),
      .ref_particle_id(ref_particle_id), .neighbor_particle_id(neighbor_particle_id),
      .refx(refx), .refy(refy), .refz(refz),
      .neighborx(neighborx), .neighbory(neighbory), .neighborz(neighborz),
      .dbg_state(dbg_state)
   );

   // Clock
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // Cache models with one cycle of read latency
   always @(posedge clk) begin
      if (ref_rd_en) ref_rd_data <= ref_mem_read(ref_rd_addr);
      if (nbr_rd_en) nbr_rd_data <= nbr_mem[nbr_rd_addr];
   end

   function automatic logic [REC_W-1:0] ref_mem_read(input logic [CELL_ADDR_WIDTH-1:0] a);
      return ref_rec[a];
   endfunction

   // Watchdog
   initial begin
      #3000000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog");
   end

   task automatic check(input string tag, input logic [255:0] got, input logic [255:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   function automatic logic [REC_W-1:0] rand_rec();
      return REC_W'({$urandom(), $urandom(), $urandom(), $urandom()});
   endfunction

   function automatic logic [2*REC_W-1:0] lane_pair(input int l);
      return {ref_particle_id[l*PARTICLE_ID_WIDTH +: PARTICLE_ID_WIDTH],
              refz[l*DATA_WIDTH +: DATA_WIDTH], refy[l*DATA_WIDTH +: DATA_WIDTH], refx[l*DATA_WIDTH +: DATA_WIDTH],
              neighbor_particle_id[l*PARTICLE_ID_WIDTH +: PARTICLE_ID_WIDTH],
              neighborz[l*DATA_WIDTH +: DATA_WIDTH], neighbory[l*DATA_WIDTH +: DATA_WIDTH],
              neighborx[l*DATA_WIDTH +: DATA_WIDTH]};
   endfunction

   function automatic logic [15:0] out_summary();
      return {busy, done, ref_rd_en, nbr_rd_en, |ref_rd_addr, |nbr_rd_addr, |input_valid,
              |ref_particle_id, |neighbor_particle_id, |refx, |refy, |refz,
              |neighborx, |neighbory, |neighborz, |dbg_state};
   endfunction

   // bp_mode: 0 none, 1 hold 4'b0100 for 5 cycles from bp_at, 2 random.
   // rst_at >= 0 pulses reset at that cycle offset and abandons the job.
   task automatic run_case(input string tag, input int rc, input int nc, input bit same,
                           input int bp_mode, input int bp_at, input int rst_at);
      int nw, w0, exp_nbr_reads, exp_done;
      int first_ref, first_nbr, first_val, last_val, done_k, ref_reads, nbr_reads, hold_words;
      logic [REC_W-1:0] word_ref;
      logic [2*REC_W-1:0] exp;

      nw = (nc + NUM_FILTER - 1) / NUM_FILTER;
      for (int i = 0; i < 256; i++) begin
         ref_rec[i] = rand_rec();
         nbr_rec[i] = rand_rec();
      end
      for (int w = 0; w < 64; w++)
         for (int l = 0; l < NUM_FILTER; l++)
            nbr_mem[w][l*REC_W +: REC_W] = nbr_rec[w*NUM_FILTER + l];

      // Reference pair list in streaming order
      exp_q.delete();
      exp_nbr_reads = 0;
      if (rc > 0 && nc > 0) begin
         for (int r = 0; r < rc; r++) begin
            w0 = same ? (r + 1) / NUM_FILTER : 0;
            if (w0 < nw) exp_nbr_reads += nw - w0;
            for (int n = 0; n < nc; n++)
               if (!same || n > r) exp_q.push_back({ref_rec[r], nbr_rec[n]});
         end
      end
      exp_done = (rc == 0 || nc == 0) ? 0 : rc * (nw + 2) + 2;

      @(negedge clk);
      ref_count = CELL_ADDR_WIDTH'(rc);
      nbr_count = CELL_ADDR_WIDTH'(nc);
      same_cell = same;
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;

      first_ref = -1; first_nbr = -1; first_val = -1; last_val = -1; done_k = -1;
      ref_reads = 0; nbr_reads = 0; hold_words = 0;
      for (int k = 0; k < 20000 && done_k < 0; k++) begin
         if (k > 0) @(negedge clk);
         if (k == 0 && rc > 0 && nc > 0) check({tag, "_busy_after_start"}, busy, 1);
         if (|input_valid) begin
            if (first_val < 0) first_val = k;
            last_val = k;
            if (bp_mode == 1 && k > bp_at && k <= bp_at + 5) hold_words++;
            word_ref = (exp_q.size() > 0) ? exp_q[0][2*REC_W-1 -: REC_W] : '0;
            for (int l = 0; l < NUM_FILTER; l++)
               check({tag, "_ref_bcast"}, lane_pair(l) >> REC_W, word_ref);
            for (int l = 0; l < NUM_FILTER; l++) begin
               if (input_valid[l]) begin
                  if (exp_q.size() == 0) begin
                     check({tag, "_extra_pair"}, input_valid[l], 0);
                  end else begin
                     exp = exp_q.pop_front();
                     check({tag, "_pair"}, lane_pair(l), exp);
                  end
               end
            end
         end
         if (done) begin
            done_k = k;
            check({tag, "_busy_at_done"}, busy, 0);
         end
         if (rst_at >= 0 && k == rst_at) begin
            rst = 1'b1;
            back_pressure_to_input = '0;
            @(negedge clk);
            check({tag, "_rst_outputs"}, out_summary(), 0);
            rst = 1'b0;
            for (int j = 0; j < 6; j++) begin
               @(negedge clk);
               check({tag, "_no_done_after_rst"}, done, 0);
               check({tag, "_idle_after_rst"}, {busy, |input_valid}, 0);
            end
            exp_q.delete();
            return;
         end
         // Stray start while busy must be ignored
         if (bp_mode == 2 && k == 3 && done_k < 0) begin
            start = 1'b1;
            ref_count = CELL_ADDR_WIDTH'($urandom_range(1, 255));
            nbr_count = CELL_ADDR_WIDTH'($urandom_range(1, 255));
         end else begin
            start = 1'b0;
         end
         case (bp_mode)
            1:       back_pressure_to_input = (k >= bp_at && k < bp_at + 5) ? 4'b0100 : 4'b0000;
            2:       back_pressure_to_input = ($urandom_range(0, 3) == 0) ? NUM_FILTER'($urandom_range(1, 15)) : '0;
            default: back_pressure_to_input = '0;
         endcase
         #1;
         if (ref_rd_en) begin
            ref_reads++;
            if (first_ref < 0) first_ref = k;
         end
         if (nbr_rd_en) begin
            nbr_reads++;
            if (first_nbr < 0) first_nbr = k;
         end
         if (|back_pressure_to_input) check({tag, "_bp_no_read"}, nbr_rd_en, 0);
      end
      back_pressure_to_input = '0;
      start = 1'b0;

      for (int j = 0; j < 2; j++) begin
         @(negedge clk);
         check({tag, "_quiet_after_done"}, {|input_valid, done}, 0);
      end

      check({tag, "_done_seen"}, done_k >= 0, 1);
      check({tag, "_missing_pairs"}, exp_q.size(), 0);
      check({tag, "_ref_reads"}, ref_reads, (rc > 0 && nc > 0) ? rc : 0);
      check({tag, "_nbr_reads"}, nbr_reads, exp_nbr_reads);
      if (bp_mode == 0 && !same) begin
         check({tag, "_done_time"}, done_k, exp_done);
         if (rc > 0 && nc > 0) begin
            check({tag, "_first_ref_rd"}, first_ref, 0);
            check({tag, "_first_nbr_rd"}, first_nbr, 2);
            check({tag, "_first_valid"}, first_val, 4);
            check({tag, "_last_valid"}, last_val, exp_done - 1);
         end
      end
      if (bp_mode == 1) check({tag, "_words_in_hold"}, hold_words <= 1, 1);
      exp_q.delete();
   endtask

   // Main sequence
   initial begin
      int rc, nc;
      bit same;
      n_checks = 0;
      n_fail = 0;
      rst = 1'b1;
      start = 1'b0;
      same_cell = 1'b0;
      ref_count = '0;
      nbr_count = '0;
      back_pressure_to_input = '0;
      repeat (3) @(negedge clk);
      check("reset_state", out_summary(), 0);
      rst = 1'b0;

      run_case("one_word",   1,   4,   0, 0, 0, -1);
      run_case("two_words",  1,   6,   0, 0, 0, -1);
      run_case("half_shell", 5,   5,   1, 0, 0, -1);
      run_case("bp_hold",    3,   40,  0, 1, 5, -1);
      run_case("rst_mid",    2,   40,  0, 0, 0, 6);
      run_case("after_rst",  2,   9,   0, 0, 0, -1);
      run_case("zero_ref",   0,   7,   0, 0, 0, -1);
      run_case("zero_nbr",   3,   0,   0, 0, 0, -1);
      run_case("full_nbr",   2,   255, 0, 0, 0, -1);
      run_case("full_cell",  255, 255, 1, 2, 0, -1);
      for (int i = 0; i < 12; i++) begin
         rc = $urandom_range(1, 10);
         same = 1'($urandom_range(0, 1));
         nc = same ? rc : $urandom_range(1, 30);
         run_case("random", rc, nc, same, 2, 0, -1);
      end

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

endmodule
